msrv32_dmem_bus_ctrl: RTL
=========================

// Module: msrv32_dmem_bus_ctrl
// PURPOSE
//  Data-memory bus sequencer directly upstream of the load unit: accepts one load/store per request from the
//  execute stage, checks alignment, drives an AHB-lite-style address/data phase, and handles wait states.
//  Builds store byte lanes and write mask. Registers read data, bus-error response and addr[1:0]/size/unsigned
//  for the load unit. Stalls the pipeline while a transfer is in flight.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max DATA-phase wait cycles before forced error (used only with MSRV32_DMEM_TIMEOUT_EN)
// PORTS
//  ms_riscv32_mp_clk_in        in   1   clock, rising edge
//  ms_riscv32_mp_rst_n_in      in   1   synchronous reset, active low
//  mem_req_in                  in   1   execute stage requests a memory op this cycle
//  mem_we_in                   in   1   1=store, 0=load
//  iadder_in                   in   32  effective byte address
//  rs2_in                      in   32  store data (unshifted)
//  load_size_in                in   2   00=byte 01=half 10/11=word (also store size)
//  load_unsigned_in            in   1   zero-extend request, passed through to load unit
//  ms_riscv32_mp_dmdata_in     in   32  bus read data
//  ahb_ready_in                in   1   bus ready (HREADY)
//  ahb_err_in                  in   1   bus error (HRESP), sampled with ahb_ready_in
//  ms_riscv32_mp_dmaddr_out    out  32  word-aligned address {iadder[31:2],2'b00}
//  ms_riscv32_mp_dmdata_out    out  32  replicated store data
//  ms_riscv32_mp_dmwr_mask_out out  4   byte write enables (0000 for loads)
//  ms_riscv32_mp_dmwr_req_out  out  1   write address-phase strobe
//  ms_riscv32_mp_dmrd_req_out  out  1   read address-phase strobe
//  stall_out                   out  1   hold pipeline
//  done_out                    out  1   one-cycle completion pulse
//  misaligned_out              out  1   one-cycle misaligned-access pulse
//  timeout_out                 out  1   one-cycle timeout pulse
//  lu_dmdata_out               out  32  captured read data -> load unit data in
//  ahb_resp_out                out  1   error response -> load unit ahb_resp_in
//  iadder_1_0_out / load_size_out / load_unsigned_out  out 2/2/1  latched request fields -> load unit
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state IDLE; every registered output 0; in-flight transfer dropped, no completion.
//  Misaligned: half with addr[0]=1, word with addr[1:0]!=0. On mem_req_in in IDLE: misaligned_out=1 next cycle,
//   no bus strobe, stall_out never asserted, state stays IDLE.
//  FSM IDLE->ADDR->DATA->(IDLE | ERR->IDLE):
//   IDLE: aligned mem_req_in -> latch addr, mask, data, size, unsigned, we; go ADDR.
//   ADDR: exactly one cycle; dmwr_req_out=we or dmrd_req_out=!we; addr/data/mask valid; go DATA.
//   DATA: addr/data/mask held; wait ahb_ready_in. ready&!err -> capture dmdata_in to lu_dmdata_out (loads only),
//         ahb_resp_out=0, done_out=1, go IDLE. ready&err -> go ERR.
//   ERR: one cycle (AHB 2-cycle error); then ahb_resp_out=1, lu_dmdata_out=0, done_out=1, go IDLE.
//  stall_out = (state!=IDLE) | (state==IDLE & mem_req_in & aligned)  (combinational).
//  Latency, zero wait: accept in cycle T, ADDR T+1, DATA T+2, done_out at T+3; +1 per wait cycle; +1 for error.
//  Store lanes: byte {4{rs2[7:0]}}, mask 4'b0001<<addr[1:0]; half {2{rs2[15:0]}}, mask 0011 (addr[1]=0) / 1100;
//   word rs2, mask 1111. Load-unit outputs hold until next accepted request; stores leave lu_dmdata_out unchanged.
//  mem_req_in while not IDLE: ignored. mem_req_in in the cycle done_out is high (state IDLE): accepted normally.
//  ahb_ready_in/ahb_err_in ignored outside DATA.
// CONFIGURATION
//  MSRV32_DMEM_TIMEOUT_EN defined: 8+ bit counter cleared on entering DATA, increments per non-ready DATA cycle;
//   reaching TIMEOUT_CYCLES -> go ERR, timeout_out=1 one cycle with done_out, ahb_resp_out=1.
//  Undefined: no counter, DATA waits indefinitely, timeout_out tied 0.
// TESTING
//  SB addr 0x0000_1003 rs2 0x1234_56A5, ready=1 -> T+1 dmaddr 0x1000, dmdata 0xA5A5A5A5, mask 1000, wr_req=1; done T+3.
//  LH addr 0x2002, 3 wait cycles, dmdata_in 0x8001_1234 -> lu_dmdata_out 0x80011234, iadder_1_0_out 10,
//   load_size_out 01, ahb_resp_out 0, stall high 6 cycles, done T+6.
//  LW addr 0x3001 -> misaligned_out pulse at T+1, no rd/wr strobe, stall_out 0, state IDLE.
//  LW addr 0x4000, ready&err in DATA -> ERR one cycle, done T+4, ahb_resp_out 1, lu_dmdata_out 0.
//  rst_n=0 during DATA of an SW -> next cycle all outputs 0, no done_out; new LB then completes normally.
//  With MSRV32_DMEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, ready stuck 0 -> timeout_out+done_out+ahb_resp_out=1 at T+7.

Source files
------------

// File: rtl/msrv32_dmem_bus_ctrl.sv
// ---------------------------------------------------------------------------
// msrv32_dmem_bus_ctrl
//   Data-memory bus sequencer in front of the load unit. It takes one load or
//   store from the execute stage, rejects misaligned accesses, runs an
//   AHB-lite-style address phase and data phase, and absorbs bus wait states.
//   It builds the store byte lanes and write mask, and registers the read
//   data, the error response and the request fields for the load unit. The
//   pipeline is stalled while a transfer is in flight.
//
// Optional feature:
//   MSRV32_DMEM_TIMEOUT_EN - when defined, a data phase that waits
//   TIMEOUT_CYCLES non-ready cycles is forced into the error path and
//   reported on timeout_out. When undefined, the data phase waits
//   indefinitely and timeout_out is tied low.
//
// Ports:
//   ms_riscv32_mp_clk_in / ms_riscv32_mp_rst_n_in : clock, sync active-low reset
//   mem_req_in, mem_we_in, iadder_in, rs2_in,
//   load_size_in, load_unsigned_in                : request from execute stage
//   ms_riscv32_mp_dmdata_in, ahb_ready_in,
//   ahb_err_in                                     : bus response
//   ms_riscv32_mp_dmaddr_out, _dmdata_out,
//   _dmwr_mask_out, _dmwr_req_out, _dmrd_req_out   : bus request
//   stall_out (combinational), done_out,
//   misaligned_out, timeout_out                    : pipeline status
//   lu_dmdata_out, ahb_resp_out, iadder_1_0_out,
//   load_size_out, load_unsigned_out               : to load unit
// ---------------------------------------------------------------------------
module msrv32_dmem_bus_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_n_in,
  input  logic        mem_req_in,
  input  logic        mem_we_in,
  input  logic [31:0] iadder_in,
  input  logic [31:0] rs2_in,
  input  logic [1:0]  load_size_in,
  input  logic        load_unsigned_in,
  input  logic [31:0] ms_riscv32_mp_dmdata_in,
  input  logic        ahb_ready_in,
  input  logic        ahb_err_in,
  output logic [31:0] ms_riscv32_mp_dmaddr_out,
  output logic [31:0] ms_riscv32_mp_dmdata_out,
  output logic [3:0]  ms_riscv32_mp_dmwr_mask_out,
  output logic        ms_riscv32_mp_dmwr_req_out,
  output logic        ms_riscv32_mp_dmrd_req_out,
  output logic        stall_out,
  output logic        done_out,
  output logic        misaligned_out,
  output logic        timeout_out,
  output logic [31:0] lu_dmdata_out,
  output logic        ahb_resp_out,
  output logic [1:0]  iadder_1_0_out,
  output logic [1:0]  load_size_out,
  output logic        load_unsigned_out
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ADDR = 2'b01,
    S_DATA = 2'b10,
    S_ERR  = 2'b11
  } state_t;

  state_t              state;
  logic                we_q;
  logic                misaligned_c;
  logic [DATA_W-1:0]   lane_data_c;
  logic [MASK_W-1:0]   lane_mask_c;

`ifdef MSRV32_DMEM_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0]    wait_cnt;
  logic                timed_out_q;
`endif

  // Alignment check: halves need addr[0]=0, words need addr[1:0]=0.
  always_comb begin
    misaligned_c = 1'b0;
    case (load_size_in)
      2'b00:   misaligned_c = 1'b0;
      2'b01:   misaligned_c = iadder_in[0];
      default: misaligned_c = |iadder_in[1:0];
    endcase
  end

  // Store lane replication and write mask; loads drive no data and no mask.
  always_comb begin
    lane_data_c = '0;
    lane_mask_c = '0;
    if (mem_we_in) begin
      case (load_size_in)
        2'b00: begin
          lane_data_c = {4{rs2_in[7:0]}};
          lane_mask_c = MASK_W'(4'b0001 << iadder_in[1:0]);
        end
        2'b01: begin
          lane_data_c = {2{rs2_in[15:0]}};
          lane_mask_c = iadder_in[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          lane_data_c = rs2_in;
          lane_mask_c = 4'b1111;
        end
      endcase
    end
  end

  // Stall covers the accepting cycle as well as every busy state.
  assign stall_out = (state != S_IDLE) | (mem_req_in & ~misaligned_c);

`ifndef MSRV32_DMEM_TIMEOUT_EN
  // Timeout disabled; the parameter stays in the port list for drop-in builds.
  assign timeout_out = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif

  // Sequencer: state plus all registered outputs.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      state                       <= S_IDLE;
      we_q                        <= 1'b0;
      ms_riscv32_mp_dmaddr_out    <= '0;
      ms_riscv32_mp_dmdata_out    <= '0;
      ms_riscv32_mp_dmwr_mask_out <= '0;
      ms_riscv32_mp_dmwr_req_out  <= 1'b0;
      ms_riscv32_mp_dmrd_req_out  <= 1'b0;
      done_out                    <= 1'b0;
      misaligned_out              <= 1'b0;
      lu_dmdata_out               <= '0;
      ahb_resp_out                <= 1'b0;
      iadder_1_0_out              <= '0;
      load_size_out               <= '0;
      load_unsigned_out           <= 1'b0;
`ifdef MSRV32_DMEM_TIMEOUT_EN
      wait_cnt                    <= '0;
      timed_out_q                 <= 1'b0;
      timeout_out                 <= 1'b0;
`endif
    end else begin
      // Single-cycle pulses default low.
      ms_riscv32_mp_dmwr_req_out <= 1'b0;
      ms_riscv32_mp_dmrd_req_out <= 1'b0;
      done_out                   <= 1'b0;
      misaligned_out             <= 1'b0;
`ifdef MSRV32_DMEM_TIMEOUT_EN
      timeout_out                <= 1'b0;
`endif

      case (state)
        S_IDLE: begin
          if (mem_req_in) begin
            if (misaligned_c) begin
              misaligned_out <= 1'b1;
            end else begin
              we_q                        <= mem_we_in;
              ms_riscv32_mp_dmaddr_out    <= {iadder_in[31:2], 2'b00};
              ms_riscv32_mp_dmdata_out    <= lane_data_c;
              ms_riscv32_mp_dmwr_mask_out <= lane_mask_c;
              ms_riscv32_mp_dmwr_req_out  <= mem_we_in;
              ms_riscv32_mp_dmrd_req_out  <= ~mem_we_in;
              iadder_1_0_out              <= iadder_in[1:0];
              load_size_out               <= load_size_in;
              load_unsigned_out           <= load_unsigned_in;
              state                       <= S_ADDR;
            end
          end
        end

        S_ADDR: begin
`ifdef MSRV32_DMEM_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state <= S_DATA;
        end

        S_DATA: begin
          if (ahb_ready_in) begin
            if (ahb_err_in) begin
              // Second cycle of the two-cycle AHB error response.
              state <= S_ERR;
            end else begin
              if (!we_q) begin
                lu_dmdata_out <= ms_riscv32_mp_dmdata_in;
              end
              ahb_resp_out <= 1'b0;
              done_out     <= 1'b1;
              state        <= S_IDLE;
            end
          end
`ifdef MSRV32_DMEM_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            timed_out_q <= 1'b1;
            state       <= S_ERR;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end

        S_ERR: begin
          ahb_resp_out  <= 1'b1;
          lu_dmdata_out <= '0;
          done_out      <= 1'b1;
`ifdef MSRV32_DMEM_TIMEOUT_EN
          timeout_out   <= timed_out_q;
          timed_out_q   <= 1'b0;
`endif
          state         <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
